// File: rtl/key_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : key_event_decoder
// Purpose  : Classifies a debounced key level into one-cycle press, release,
//            click, double-click, long-press and (optional) auto-repeat pulses.
//            Define KEY_REPEAT_EN to enable auto-repeat while held after long.
// Revision : 1.0 - initial release
// ============================================================================
module key_event_decoder #(
  parameter logic [15:0] T1MS    = 16'd49_999,
  parameter logic [15:0] LONG_MS = 16'd1000,
  parameter logic [15:0] DBL_MS  = 16'd250,
  parameter logic [15:0] REP_MS  = 16'd100
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic Key_In,
  output logic Press_Sig,
  output logic Release_Sig,
  output logic Click_Sig,
  output logic Dbl_Sig,
  output logic Long_Sig,
  output logic Rep_Sig
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRESS1 = 3'd1;
  localparam logic [2:0] S_LONG   = 3'd2;
  localparam logic [2:0] S_WAIT2  = 3'd3;
  localparam logic [2:0] S_PRESS2 = 3'd4;

  logic        k_d;
  logic        rise;
  logic        fall;
  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic [15:0] pre_cnt;
  logic [15:0] ms_cnt;
  logic        tick;
  logic        run_timer;
  logic        clear_cnt;
  logic        press_nx;
  logic        release_nx;
  logic        click_nx;
  logic        dbl_nx;
  logic        long_nx;

  // k_d powers up as "pressed" so a key held through reset must be released first
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      k_d <= 1'b1;
    end else begin
      k_d <= Key_In;
    end
  end

  assign rise = Key_In & ~k_d;
  assign fall = ~Key_In & k_d;
  assign tick = (pre_cnt == T1MS);

`ifdef KEY_REPEAT_EN
  localparam logic [15:0] REP_LAST = REP_MS - 16'd1;
  logic rep_nx;

  // Repeat fires on the tick that would take ms to REP_MS, giving an exact REP_MS period
  assign run_timer = (state == S_PRESS1) || (state == S_WAIT2) || (state == S_LONG);
`else
  assign run_timer = (state == S_PRESS1) || (state == S_WAIT2);
`endif

  always_comb begin
    state_nx   = state;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    click_nx   = 1'b0;
    dbl_nx     = 1'b0;
    long_nx    = 1'b0;
    clear_cnt  = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_nx     = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (rise) begin
          press_nx = 1'b1;
          state_nx = S_PRESS1;
        end
      end
      S_PRESS1: begin
        if (fall) begin
          release_nx = 1'b1;
          state_nx   = S_WAIT2;
        end else if (ms_cnt == LONG_MS) begin
          long_nx  = 1'b1;
          state_nx = S_LONG;
        end
      end
      S_LONG: begin
        if (fall) begin
          release_nx = 1'b1;
          state_nx   = S_IDLE;
        end
`ifdef KEY_REPEAT_EN
        else if (tick && (ms_cnt == REP_LAST)) begin
          rep_nx    = 1'b1;
          clear_cnt = 1'b1;
        end
`endif
      end
      S_WAIT2: begin
        if (rise) begin
          press_nx = 1'b1;
          dbl_nx   = 1'b1;
          state_nx = S_PRESS2;
        end else if (ms_cnt == DBL_MS) begin
          click_nx = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_PRESS2: begin
        if (fall) begin
          release_nx = 1'b1;
          state_nx   = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    if (state_nx != state) begin
      clear_cnt = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pre_cnt <= 16'd0;
      ms_cnt  <= 16'd0;
    end else if (!run_timer || clear_cnt) begin
      pre_cnt <= 16'd0;
      ms_cnt  <= 16'd0;
    end else if (tick) begin
      pre_cnt <= 16'd0;
      ms_cnt  <= ms_cnt + 16'd1;
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Press_Sig   <= 1'b0;
      Release_Sig <= 1'b0;
      Click_Sig   <= 1'b0;
      Dbl_Sig     <= 1'b0;
      Long_Sig    <= 1'b0;
    end else begin
      Press_Sig   <= press_nx;
      Release_Sig <= release_nx;
      Click_Sig   <= click_nx;
      Dbl_Sig     <= dbl_nx;
      Long_Sig    <= long_nx;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Rep_Sig <= 1'b0;
    end else begin
      Rep_Sig <= rep_nx;
    end
  end
`else
  assign Rep_Sig = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_event_decoder
// Purpose  : Self-checking bench for key_event_decoder; expected pulses come
//            from a timestamp-based gesture model (honours KEY_REPEAT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_event_decoder;

  localparam int T1MS     = 9;
  localparam int LONG_MS  = 20;
  localparam int DBL_MS   = 5;
  localparam int REP_MS   = 4;
  localparam int MS_CYC   = T1MS + 1;
  localparam int LONG_CYC = LONG_MS * MS_CYC + 1;
  localparam int DBL_CYC  = DBL_MS * MS_CYC + 1;
  localparam int REP_CYC  = REP_MS * MS_CYC;
  localparam int MAXN     = 4096;

  localparam int B_PRESS = 0;
  localparam int B_REL   = 1;
  localparam int B_CLICK = 2;
  localparam int B_DBL   = 3;
  localparam int B_LONG  = 4;
  localparam int B_REP   = 5;

  localparam int G_NONE   = 0;
  localparam int G_HELD   = 1;
  localparam int G_GAP    = 2;
  localparam int G_SECOND = 3;

  logic CLK    = 1'b0;
  logic RSTn   = 1'b0;
  logic Key_In = 1'b0;
  logic Press_Sig, Release_Sig, Click_Sig, Dbl_Sig, Long_Sig, Rep_Sig;

  int checks = 0;
  int errors = 0;

  logic       keyseq [0:MAXN-1];
  logic [5:0] expv   [0:MAXN-1];
  int         n = 0;

  key_event_decoder #(
    .T1MS   (16'd9),
    .LONG_MS(16'd20),
    .DBL_MS (16'd5),
    .REP_MS (16'd4)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .Key_In     (Key_In),
    .Press_Sig  (Press_Sig),
    .Release_Sig(Release_Sig),
    .Click_Sig  (Click_Sig),
    .Dbl_Sig    (Dbl_Sig),
    .Long_Sig   (Long_Sig),
    .Rep_Sig    (Rep_Sig)
  );

  always #5 CLK = ~CLK;

  function automatic logic [5:0] outs();
    return {Rep_Sig, Long_Sig, Dbl_Sig, Click_Sig, Release_Sig, Press_Sig};
  endfunction

  task automatic add_seg(input logic lvl, input int len);
    for (int i = 0; i < len; i++) begin
      if (n < MAXN) begin
        keyseq[n] = lvl;
        n++;
      end
    end
  endtask

  function automatic void put(input int t, input int b);
    if (t >= 0 && t < n) expv[t][b] = 1'b1;
  endfunction

  function automatic void emit_long(input int pressed_at, input int stop);
    put(pressed_at + LONG_CYC, B_LONG);
`ifdef KEY_REPEAT_EN
    for (int t = pressed_at + LONG_CYC + REP_CYC; t < stop; t += REP_CYC) put(t, B_REP);
`endif
  endfunction

  // Gesture model: works on key edge timestamps and deadline arithmetic
  task automatic build_model();
    logic prev;
    int   et[$];
    logic eu[$];
    int   phase;
    int   anchor;
    for (int c = 0; c < n; c++) expv[c] = '0;
    prev = 1'b1;
    for (int c = 0; c < n; c++) begin
      if (keyseq[c] !== prev) begin
        et.push_back(c);
        eu.push_back(keyseq[c]);
        prev = keyseq[c];
      end
    end
    phase  = G_NONE;
    anchor = 0;
    foreach (et[i]) begin
      if (phase == G_NONE) begin
        if (eu[i]) begin
          put(et[i], B_PRESS);
          phase  = G_HELD;
          anchor = et[i];
        end
      end else if (phase == G_HELD) begin
        if (et[i] <= anchor + LONG_CYC) begin
          put(et[i], B_REL);
          phase  = G_GAP;
          anchor = et[i];
        end else begin
          emit_long(anchor, et[i]);
          put(et[i], B_REL);
          phase = G_NONE;
        end
      end else if (phase == G_GAP) begin
        if (et[i] <= anchor + DBL_CYC) begin
          put(et[i], B_PRESS);
          put(et[i], B_DBL);
          phase = G_SECOND;
        end else begin
          put(anchor + DBL_CYC, B_CLICK);
          put(et[i], B_PRESS);
          phase  = G_HELD;
          anchor = et[i];
        end
      end else begin
        put(et[i], B_REL);
        phase = G_NONE;
      end
    end
    if (phase == G_HELD) emit_long(anchor, n);
    if (phase == G_GAP) put(anchor + DBL_CYC, B_CLICK);
  endtask

  task automatic run_seq(input string name);
    logic [5:0] got;
    build_model();
    for (int c = 0; c < n; c++) begin
      Key_In = keyseq[c];
      @(negedge CLK);
      got = outs();
      checks++;
      if (got !== expv[c]) begin
        errors++;
        $display("FAIL %s cycle %0d: got %b expected %b (rep,long,dbl,click,rel,press)",
                 name, c, got, expv[c]);
      end
    end
  endtask

  task automatic do_reset(input logic lvl);
    @(negedge CLK);
    RSTn   = 1'b0;
    Key_In = lvl;
    repeat (3) @(negedge CLK);
    checks++;
    if (outs() !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000", outs());
    end
    RSTn = 1'b1;
    n    = 0;
  endtask

  task automatic mid_reset(input string name);
    RSTn = 1'b0;
    #1;
    checks++;
    if (outs() !== 6'b0) begin
      errors++;
      $display("FAIL %s: got %b expected 000000 right after reset", name, outs());
    end
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    n    = 0;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    add_seg(1'b1, 300);
    add_seg(1'b0, 20);
    add_seg(1'b1, 5);
    add_seg(1'b0, 80);
    run_seq("reset_hold");
  endtask

  task automatic test_click();
    do_reset(1'b0);
    add_seg(1'b0, 5);
    add_seg(1'b1, 50);
    add_seg(1'b0, 70);
    run_seq("click");
  endtask

  task automatic test_double();
    do_reset(1'b0);
    add_seg(1'b0, 5);
    add_seg(1'b1, 30);
    add_seg(1'b0, 20);
    add_seg(1'b1, 30);
    add_seg(1'b0, 80);
    run_seq("double");
  endtask

  task automatic test_long();
    do_reset(1'b0);
    add_seg(1'b0, 5);
    add_seg(1'b1, 300);
    add_seg(1'b0, 60);
    run_seq("long_hold");
  endtask

  task automatic test_thresholds();
    do_reset(1'b0);
    add_seg(1'b0, 5);
    add_seg(1'b1, LONG_CYC);
    add_seg(1'b0, DBL_CYC);
    add_seg(1'b1, 10);
    add_seg(1'b0, 80);
    run_seq("exact_thresholds");
    do_reset(1'b0);
    add_seg(1'b0, 5);
    add_seg(1'b1, LONG_CYC + 1);
    add_seg(1'b0, DBL_CYC + 1);
    add_seg(1'b1, 10);
    add_seg(1'b0, 80);
    run_seq("past_thresholds");
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    add_seg(1'b0, 5);
    add_seg(1'b1, 1);
    run_seq("mid_press1_a");
    mid_reset("mid_press1_clear");
    add_seg(1'b1, 300);
    add_seg(1'b0, 60);
    run_seq("mid_press1_b");
    do_reset(1'b0);
    add_seg(1'b0, 5);
    add_seg(1'b1, 30);
    add_seg(1'b0, 1);
    run_seq("mid_wait2_a");
    mid_reset("mid_wait2_clear");
    add_seg(1'b0, 100);
    run_seq("mid_wait2_b");
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    add_seg(1'b0, 3);
    add_seg(1'b1, 1);
    add_seg(1'b0, 1);
    add_seg(1'b1, 1);
    add_seg(1'b0, 1);
    add_seg(1'b1, 2);
    add_seg(1'b0, 1);
    add_seg(1'b1, 1);
    add_seg(1'b0, 70);
    run_seq("back_to_back");
  endtask

  task automatic test_random();
    int pick;
    for (int r = 0; r < 4; r++) begin
      do_reset(logic'($urandom_range(0, 1)));
      while (n < MAXN - 600) begin
        pick = int'($urandom_range(0, 9));
        if (pick == 0)      add_seg(1'b1, LONG_CYC - 1 + int'($urandom_range(0, 2)));
        else if (pick <= 2) add_seg(1'b1, int'($urandom_range(200, 330)));
        else                add_seg(1'b1, int'($urandom_range(1, 60)));
        pick = int'($urandom_range(0, 4));
        if (pick == 0) add_seg(1'b0, DBL_CYC - 1 + int'($urandom_range(0, 2)));
        else           add_seg(1'b0, int'($urandom_range(1, 80)));
      end
      add_seg(1'b0, 120);
      run_seq("random");
    end
  endtask

  initial begin
    test_reset();
    test_click();
    test_double();
    test_long();
    test_thresholds();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
